// File: rtl/scpad_dram_responder_if.sv
// Backend DRAM request/response channel plus downstream memory port of scpad_dram_responder.
// slave is the responder's view; master is the backend/memory side that drives it.
interface scpad_dram_responder_if #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned ID_W      = 8,
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned MASK_W    = 4,
  parameter int unsigned MAX_OUTST = 8
);
  localparam int unsigned OCNT_W = $clog2(MAX_OUTST) + 1;

  logic              req_valid;
  logic              req_write;
  logic [ID_W-1:0]   req_id;
  logic [ADDR_W-1:0] req_addr;
  logic [MASK_W-1:0] req_mask;
  logic [DATA_W-1:0] req_wdata;
  logic              dram_be_stall;
  logic              be_dram_stall;
  logic              res_valid;
  logic [ID_W-1:0]   res_id;
  logic [DATA_W-1:0] res_rdata;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic              mem_req_write;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [MASK_W-1:0] mem_req_wmask;
  logic [DATA_W-1:0] mem_req_wdata;
  logic              mem_rsp_valid;
  logic              mem_rsp_ready;
  logic [DATA_W-1:0] mem_rsp_rdata;
  logic [OCNT_W-1:0] outst_count;
  logic              proto_err;

  modport slave (
    input  req_valid, req_write, req_id, req_addr, req_mask, req_wdata, be_dram_stall,
           mem_req_ready, mem_rsp_valid, mem_rsp_rdata,
    output dram_be_stall, res_valid, res_id, res_rdata, mem_req_valid, mem_req_write,
           mem_req_addr, mem_req_wmask, mem_req_wdata, mem_rsp_ready, outst_count, proto_err
  );

  modport master (
    output req_valid, req_write, req_id, req_addr, req_mask, req_wdata, be_dram_stall,
           mem_req_ready, mem_rsp_valid, mem_rsp_rdata,
    input  dram_be_stall, res_valid, res_id, res_rdata, mem_req_valid, mem_req_write,
           mem_req_addr, mem_req_wmask, mem_req_wdata, mem_rsp_ready, outst_count, proto_err
  );
endinterface

// File: rtl/scpad_dram_responder.sv
// Memory-side endpoint of the scratchpad DRAM channel: in-order request FIFO to a memory
// port, tag FIFO for outstanding reads, and a one-entry masked response register.
module scpad_dram_responder #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned ID_W      = 8,
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned MASK_W    = 4,
  parameter int unsigned REQ_DEPTH = 4,
  parameter int unsigned MAX_OUTST = 8
) (
  input logic                   clk,
  input logic                   n_rst,
  scpad_dram_responder_if.slave bus
);
  localparam int unsigned LANE_W = DATA_W / MASK_W;
  localparam int unsigned RPTR_W = $clog2(REQ_DEPTH);
  localparam int unsigned TPTR_W = $clog2(MAX_OUTST);
  localparam int unsigned OCNT_W = TPTR_W + 1;
  localparam logic [RPTR_W:0] ReqFullCnt = (RPTR_W + 1)'(REQ_DEPTH);
  localparam logic [TPTR_W:0] TagFullCnt = (TPTR_W + 1)'(MAX_OUTST);

  logic              req_write_q [REQ_DEPTH];
  logic              req_write_d [REQ_DEPTH];
  logic [ID_W-1:0]   req_id_q    [REQ_DEPTH];
  logic [ID_W-1:0]   req_id_d    [REQ_DEPTH];
  logic [ADDR_W-1:0] req_addr_q  [REQ_DEPTH];
  logic [ADDR_W-1:0] req_addr_d  [REQ_DEPTH];
  logic [MASK_W-1:0] req_mask_q  [REQ_DEPTH];
  logic [MASK_W-1:0] req_mask_d  [REQ_DEPTH];
  logic [DATA_W-1:0] req_wdata_q [REQ_DEPTH];
  logic [DATA_W-1:0] req_wdata_d [REQ_DEPTH];
  logic [RPTR_W-1:0] req_wptr_q, req_wptr_d, req_rptr_q, req_rptr_d;
  logic [RPTR_W:0]   req_cnt_q, req_cnt_d;

  logic [ID_W-1:0]   tag_id_q    [MAX_OUTST];
  logic [ID_W-1:0]   tag_id_d    [MAX_OUTST];
  logic [MASK_W-1:0] tag_mask_q  [MAX_OUTST];
  logic [MASK_W-1:0] tag_mask_d  [MAX_OUTST];
  logic [TPTR_W-1:0] tag_wptr_q, tag_wptr_d, tag_rptr_q, tag_rptr_d;
  logic [TPTR_W:0]   tag_cnt_q, tag_cnt_d;

  logic              res_valid_q, res_valid_d;
  logic [ID_W-1:0]   res_id_q, res_id_d;
  logic [DATA_W-1:0] res_rdata_q, res_rdata_d;
  logic [OCNT_W-1:0] outst_q, outst_d;
  logic              proto_err_q, proto_err_d;

  logic req_full, req_empty, tag_full, tag_empty, head_write, issue_valid;
  logic req_push, req_pop, tag_push, rsp_ready, rsp_take, res_xfer;

  always_comb begin
    req_full    = (req_cnt_q == ReqFullCnt);
    req_empty   = (req_cnt_q == '0);
    tag_full    = (tag_cnt_q == TagFullCnt);
    tag_empty   = (tag_cnt_q == '0);
    head_write  = req_write_q[req_rptr_q];
    // A read at the head blocks everything behind it while the tag FIFO is full.
    issue_valid = !req_empty && (head_write || !tag_full);
    req_push    = bus.req_valid && !req_full;
    req_pop     = issue_valid && bus.mem_req_ready;
    tag_push    = req_pop && !head_write;
    rsp_ready   = !res_valid_q || !bus.be_dram_stall;
    rsp_take    = bus.mem_rsp_valid && rsp_ready && !tag_empty;
    res_xfer    = res_valid_q && !bus.be_dram_stall;
  end

  always_comb begin
    req_write_d = req_write_q;
    req_id_d    = req_id_q;
    req_addr_d  = req_addr_q;
    req_mask_d  = req_mask_q;
    req_wdata_d = req_wdata_q;
    req_wptr_d  = req_wptr_q;
    req_rptr_d  = req_rptr_q;
    tag_id_d    = tag_id_q;
    tag_mask_d  = tag_mask_q;
    tag_wptr_d  = tag_wptr_q;
    tag_rptr_d  = tag_rptr_q;
    res_valid_d = res_valid_q;
    res_id_d    = res_id_q;
    res_rdata_d = res_rdata_q;

    if (req_push) begin
      req_write_d[req_wptr_q] = bus.req_write;
      req_id_d[req_wptr_q]    = bus.req_id;
      req_addr_d[req_wptr_q]  = bus.req_addr;
      req_mask_d[req_wptr_q]  = bus.req_mask;
      req_wdata_d[req_wptr_q] = bus.req_wdata;
      req_wptr_d              = req_wptr_q + 1'b1;
    end
    if (req_pop) req_rptr_d = req_rptr_q + 1'b1;
    req_cnt_d = req_cnt_q + (RPTR_W + 1)'(req_push) - (RPTR_W + 1)'(req_pop);

    if (tag_push) begin
      tag_id_d[tag_wptr_q]   = req_id_q[req_rptr_q];
      tag_mask_d[tag_wptr_q] = req_mask_q[req_rptr_q];
      tag_wptr_d             = tag_wptr_q + 1'b1;
    end
    if (rsp_take) tag_rptr_d = tag_rptr_q + 1'b1;
    tag_cnt_d = tag_cnt_q + (TPTR_W + 1)'(tag_push) - (TPTR_W + 1)'(rsp_take);

    if (rsp_take) begin
      res_valid_d = 1'b1;
      res_id_d    = tag_id_q[tag_rptr_q];
      for (int i = 0; i < int'(MASK_W); i++) begin
        res_rdata_d[i*LANE_W +: LANE_W] = tag_mask_q[tag_rptr_q][i] ?
                                          bus.mem_rsp_rdata[i*LANE_W +: LANE_W] : '0;
      end
    end else if (res_xfer) begin
      res_valid_d = 1'b0;
    end

    // The holding register still counts as outstanding until the backend takes it.
    outst_d     = outst_q + OCNT_W'(tag_push) - OCNT_W'(res_xfer);
    proto_err_d = proto_err_q | (bus.mem_rsp_valid && tag_empty);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < int'(REQ_DEPTH); i++) begin
        req_write_q[i] <= 1'b0;
        req_id_q[i]    <= '0;
        req_addr_q[i]  <= '0;
        req_mask_q[i]  <= '0;
        req_wdata_q[i] <= '0;
      end
      for (int i = 0; i < int'(MAX_OUTST); i++) begin
        tag_id_q[i]   <= '0;
        tag_mask_q[i] <= '0;
      end
      req_wptr_q  <= '0;
      req_rptr_q  <= '0;
      req_cnt_q   <= '0;
      tag_wptr_q  <= '0;
      tag_rptr_q  <= '0;
      tag_cnt_q   <= '0;
      res_valid_q <= 1'b0;
      res_id_q    <= '0;
      res_rdata_q <= '0;
      outst_q     <= '0;
      proto_err_q <= 1'b0;
    end else begin
      req_write_q <= req_write_d;
      req_id_q    <= req_id_d;
      req_addr_q  <= req_addr_d;
      req_mask_q  <= req_mask_d;
      req_wdata_q <= req_wdata_d;
      req_wptr_q  <= req_wptr_d;
      req_rptr_q  <= req_rptr_d;
      req_cnt_q   <= req_cnt_d;
      tag_id_q    <= tag_id_d;
      tag_mask_q  <= tag_mask_d;
      tag_wptr_q  <= tag_wptr_d;
      tag_rptr_q  <= tag_rptr_d;
      tag_cnt_q   <= tag_cnt_d;
      res_valid_q <= res_valid_d;
      res_id_q    <= res_id_d;
      res_rdata_q <= res_rdata_d;
      outst_q     <= outst_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign bus.dram_be_stall = req_full;
  assign bus.mem_req_valid = issue_valid;
  assign bus.mem_req_write = head_write;
  assign bus.mem_req_addr  = req_addr_q[req_rptr_q];
  assign bus.mem_req_wmask = req_mask_q[req_rptr_q];
  assign bus.mem_req_wdata = req_wdata_q[req_rptr_q];
  assign bus.mem_rsp_ready = rsp_ready;
  assign bus.res_valid     = res_valid_q;
  assign bus.res_id        = res_id_q;
  assign bus.res_rdata     = res_rdata_q;
  assign bus.outst_count   = outst_q;
  assign bus.proto_err     = proto_err_q;
endmodule

// File: tb/tb_scpad_dram_responder.sv
// Scoreboard bench for scpad_dram_responder: directed traffic, with issue and response
// monitors popping hand-computed expectations.
module tb_scpad_dram_responder;
  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [63:0] wdata;
  } iss_t;
  typedef struct packed {
    logic [7:0]  id;
    logic [63:0] data;
  } rsp_t;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  iss_t iss_q[$];
  rsp_t rsp_q[$];

  scpad_dram_responder_if #(
    .ADDR_W(32), .ID_W(8), .DATA_W(64), .MASK_W(4), .MAX_OUTST(8)
  ) bus ();

  scpad_dram_responder #(
    .ADDR_W(32), .ID_W(8), .DATA_W(64), .MASK_W(4), .REQ_DEPTH(4), .MAX_OUTST(8)
  ) u_dut (
    .clk  (clk),
    .n_rst(n_rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: bound expired", nm);
  endtask

  // Issue monitor
  always @(negedge clk) begin
    if (n_rst && bus.mem_req_valid && bus.mem_req_ready) begin
      if (iss_q.size() == 0) begin
        fail_now("unexpected_issue");
      end else begin
        iss_t e;
        e = iss_q.pop_front();
        chk("issue_write", 64'(bus.mem_req_write), 64'(e.write));
        chk("issue_addr", 64'(bus.mem_req_addr), 64'(e.addr));
        chk("issue_wmask", 64'(bus.mem_req_wmask), 64'(e.mask));
        chk("issue_wdata", bus.mem_req_wdata, e.wdata);
      end
    end
  end

  // Response monitor
  always @(negedge clk) begin
    if (n_rst && bus.res_valid && !bus.be_dram_stall) begin
      if (rsp_q.size() == 0) begin
        fail_now("unexpected_response");
      end else begin
        rsp_t e;
        e = rsp_q.pop_front();
        chk("rsp_id", 64'(bus.res_id), 64'(e.id));
        chk("rsp_rdata", bus.res_rdata, e.data);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send(input logic w, input logic [7:0] id, input logic [31:0] addr,
                      input logic [3:0] mask, input logic [63:0] wd);
    int n = 0;
    bus.req_valid = 1'b1;
    bus.req_write = w;
    bus.req_id    = id;
    bus.req_addr  = addr;
    bus.req_mask  = mask;
    bus.req_wdata = wd;
    iss_q.push_back('{write: w, addr: addr, mask: mask, wdata: wd});
    @(negedge clk);
    while (bus.dram_be_stall && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (bus.dram_be_stall) fail_now("send_accept");
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic mem_return(input logic [63:0] data, input logic [7:0] exp_id,
                            input logic [63:0] exp_data);
    int n = 0;
    rsp_q.push_back('{id: exp_id, data: exp_data});
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_rdata = data;
    @(negedge clk);
    while (!bus.mem_rsp_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.mem_rsp_ready) fail_now("mem_rsp_accept");
    @(posedge clk);
    #1;
    bus.mem_rsp_valid = 1'b0;
  endtask

  task automatic wait_issued(input string nm);
    int n = 0;
    while (iss_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (iss_q.size() != 0) fail_now(nm);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string pfx);
    chk({pfx, "_stall"}, 64'(bus.dram_be_stall), 64'd0);
    chk({pfx, "_res_valid"}, 64'(bus.res_valid), 64'd0);
    chk({pfx, "_res_id"}, 64'(bus.res_id), 64'd0);
    chk({pfx, "_res_rdata"}, bus.res_rdata, 64'd0);
    chk({pfx, "_mem_req_valid"}, 64'(bus.mem_req_valid), 64'd0);
    chk({pfx, "_mem_req_write"}, 64'(bus.mem_req_write), 64'd0);
    chk({pfx, "_mem_req_addr"}, 64'(bus.mem_req_addr), 64'd0);
    chk({pfx, "_mem_req_wmask"}, 64'(bus.mem_req_wmask), 64'd0);
    chk({pfx, "_mem_req_wdata"}, bus.mem_req_wdata, 64'd0);
    chk({pfx, "_mem_rsp_ready"}, 64'(bus.mem_rsp_ready), 64'd1);
    chk({pfx, "_outst"}, 64'(bus.outst_count), 64'd0);
    chk({pfx, "_proto_err"}, 64'(bus.proto_err), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid     = 1'b0;
    bus.req_write     = 1'b0;
    bus.req_id        = '0;
    bus.req_addr      = '0;
    bus.req_mask      = '0;
    bus.req_wdata     = '0;
    bus.be_dram_stall = 1'b0;
    bus.mem_req_ready = 1'b1;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_rdata = '0;
    #2;
    chk_reset("reset");
    @(negedge clk);
    n_rst = 1'b1;
    @(posedge clk);
    #1;

    // Single read with partial lane mask
    send(1'b0, 8'h0B, 32'h100, 4'b0011, 64'h0);
    @(negedge clk);
    chk("single_issue_latency", 64'(bus.mem_req_valid), 64'd1);
    @(posedge clk);
    #1;
    mem_return(64'h1111_2222_3333_4444, 8'h0B, 64'h0000_0000_3333_4444);
    @(negedge clk);
    chk("single_rsp_latency", 64'(bus.res_valid), 64'd1);
    chk("single_outst_held", 64'(bus.outst_count), 64'd1);
    idle(1);
    @(negedge clk);
    chk("single_outst_done", 64'(bus.outst_count), 64'd0);
    @(posedge clk);
    #1;

    // Fill the request FIFO while downstream stalls
    bus.mem_req_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(1'b0, 8'h10 + 8'(i), 32'h1000 + 32'(i * 8), 4'hF, 64'h0);
    @(negedge clk);
    chk("fill_stall", 64'(bus.dram_be_stall), 64'd1);
    chk("fill_head_valid", 64'(bus.mem_req_valid), 64'd1);
    bus.req_valid = 1'b1;
    bus.req_id    = 8'h14;
    bus.req_addr  = 32'h1020;
    repeat (2) begin
      @(negedge clk);
      chk("fill_hold", 64'(bus.dram_be_stall), 64'd1);
    end
    @(posedge clk);
    #1;
    bus.mem_req_ready = 1'b1;
    send(1'b0, 8'h14, 32'h1020, 4'hF, 64'h0);
    wait_issued("fill_issue");
    chk("fill_outst", 64'(bus.outst_count), 64'd5);
    mem_return(64'h1010_0101_A5A5_0010, 8'h10, 64'h1010_0101_A5A5_0010);
    mem_return(64'h1111_0101_A5A5_0011, 8'h11, 64'h1111_0101_A5A5_0011);
    mem_return(64'h1212_0101_A5A5_0012, 8'h12, 64'h1212_0101_A5A5_0012);
    mem_return(64'h1313_0101_A5A5_0013, 8'h13, 64'h1313_0101_A5A5_0013);
    mem_return(64'h1414_0101_A5A5_0014, 8'h14, 64'h1414_0101_A5A5_0014);
    idle(2);
    chk("fill_outst_done", 64'(bus.outst_count), 64'd0);

    // Response backpressure
    bus.be_dram_stall = 1'b1;
    send(1'b0, 8'h21, 32'h2000, 4'b0001, 64'h0);
    send(1'b0, 8'h22, 32'h2008, 4'b1000, 64'h0);
    send(1'b0, 8'h23, 32'h2010, 4'b0110, 64'h0);
    wait_issued("bp_issue");
    rsp_q.push_back('{id: 8'h21, data: 64'h0000_0000_0000_DEF0});
    rsp_q.push_back('{id: 8'h22, data: 64'hCAFE_0000_0000_0000});
    rsp_q.push_back('{id: 8'h23, data: 64'h0000_F0F0_AAAA_0000});
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_rdata = 64'h1234_5678_9ABC_DEF0;
    @(posedge clk);
    #1;
    bus.mem_rsp_rdata = 64'hCAFE_BABE_DEAD_BEEF;
    repeat (3) begin
      @(negedge clk);
      chk("bp_hold_valid", 64'(bus.res_valid), 64'd1);
      chk("bp_hold_id", 64'(bus.res_id), 64'h21);
      chk("bp_hold_rdata", bus.res_rdata, 64'h0000_0000_0000_DEF0);
      chk("bp_mem_rsp_ready", 64'(bus.mem_rsp_ready), 64'd0);
    end
    @(posedge clk);
    #1;
    bus.be_dram_stall = 1'b0;
    @(negedge clk);
    chk("bp_consec1", 64'(bus.res_valid), 64'd1);
    @(posedge clk);
    #1;
    bus.mem_rsp_rdata = 64'h0F0F_F0F0_AAAA_5555;
    @(negedge clk);
    chk("bp_consec2", 64'(bus.res_valid), 64'd1);
    @(posedge clk);
    #1;
    bus.mem_rsp_valid = 1'b0;
    @(negedge clk);
    chk("bp_consec3", 64'(bus.res_valid), 64'd1);
    idle(2);
    chk("bp_outst_done", 64'(bus.outst_count), 64'd0);

    // Mixed write then read
    send(1'b1, 8'h08, 32'h200, 4'b1111, 64'h0123_4567_89AB_CDEF);
    send(1'b0, 8'h09, 32'h208, 4'b0101, 64'h0);
    wait_issued("mixed_issue");
    @(negedge clk);
    chk("mixed_outst1", 64'(bus.outst_count), 64'd1);
    chk("mixed_no_wr_rsp", 64'(bus.res_valid), 64'd0);
    @(posedge clk);
    #1;
    mem_return(64'hAAAA_BBBB_CCCC_DDDD, 8'h09, 64'h0000_BBBB_0000_DDDD);
    idle(2);
    chk("mixed_outst0", 64'(bus.outst_count), 64'd0);

    // Tag limit blocks a read and the write behind it
    for (int i = 0; i < 8; i++) send(1'b0, 8'h30 + 8'(i), 32'h3000 + 32'(i * 8), 4'hF, 64'h0);
    wait_issued("tag_fill_issue");
    chk("tag_outst_max", 64'(bus.outst_count), 64'd8);
    send(1'b0, 8'h38, 32'h3040, 4'b1000, 64'h0);
    send(1'b1, 8'h39, 32'h3048, 4'b0011, 64'h5555_6666_7777_8888);
    repeat (3) @(negedge clk);
    chk("tag_block_valid", 64'(bus.mem_req_valid), 64'd0);
    chk("tag_block_pending", 64'(iss_q.size()), 64'd2);
    @(posedge clk);
    #1;
    mem_return(64'h3030_3030_3030_3030, 8'h30, 64'h3030_3030_3030_3030);
    wait_issued("tag_resume");
    mem_return(64'h3131_0000_0000_0031, 8'h31, 64'h3131_0000_0000_0031);
    mem_return(64'h3232_0000_0000_0032, 8'h32, 64'h3232_0000_0000_0032);
    mem_return(64'h3333_0000_0000_0033, 8'h33, 64'h3333_0000_0000_0033);
    mem_return(64'h3434_0000_0000_0034, 8'h34, 64'h3434_0000_0000_0034);
    mem_return(64'h3535_0000_0000_0035, 8'h35, 64'h3535_0000_0000_0035);
    mem_return(64'h3636_0000_0000_0036, 8'h36, 64'h3636_0000_0000_0036);
    mem_return(64'h3737_0000_0000_0037, 8'h37, 64'h3737_0000_0000_0037);
    mem_return(64'hFFFF_EEEE_DDDD_CCCC, 8'h38, 64'hFFFF_0000_0000_0000);
    idle(2);
    chk("tag_outst_done", 64'(bus.outst_count), 64'd0);

    // Response with no outstanding tag
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_rdata = 64'hDEAD;
    @(posedge clk);
    #1;
    bus.mem_rsp_valid = 1'b0;
    @(negedge clk);
    chk("err_proto", 64'(bus.proto_err), 64'd1);
    chk("err_no_res", 64'(bus.res_valid), 64'd0);
    chk("err_outst", 64'(bus.outst_count), 64'd0);
    @(posedge clk);
    #1;

    // Reset in the middle of traffic
    send(1'b0, 8'h40, 32'h4000, 4'hF, 64'h0);
    wait_issued("rst_issue");
    bus.mem_req_ready = 1'b0;
    send(1'b0, 8'h41, 32'h4008, 4'hF, 64'h0);
    send(1'b0, 8'h42, 32'h4010, 4'hF, 64'h0);
    bus.be_dram_stall = 1'b1;
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_rdata = 64'h4040_4040_4040_4040;
    @(posedge clk);
    #1;
    bus.mem_rsp_valid = 1'b0;
    #2;
    n_rst = 1'b0;
    #1;
    iss_q.delete();
    chk_reset("midrst");
    @(negedge clk);
    n_rst = 1'b1;
    bus.be_dram_stall = 1'b0;
    bus.mem_req_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("no_replay_req", 64'(bus.mem_req_valid), 64'd0);
      chk("no_replay_rsp", 64'(bus.res_valid), 64'd0);
    end
    @(posedge clk);
    #1;
    send(1'b0, 8'h50, 32'h5000, 4'hF, 64'h0);
    wait_issued("post_rst_issue");
    mem_return(64'h7777_8888_9999_AAAA, 8'h50, 64'h7777_8888_9999_AAAA);
    idle(2);
    chk("post_rst_outst", 64'(bus.outst_count), 64'd0);
    chk("post_rst_proto", 64'(bus.proto_err), 64'd0);
    chk("end_iss_pending", 64'(iss_q.size()), 64'd0);
    chk("end_rsp_pending", 64'(rsp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
